// File: rtl/green_time_adapter_if.sv
// Bus between a phase sequencer and the green-time adaptation engine.
//
// Handshake: start is a request level sampled on the rising clock edge.
// It is only acted on while the engine is idle. busy rises on the cycle
// after acceptance. done is a single-cycle pulse. tg_out, tot and avg
// hold their value from that cycle until the next done pulse or reset.
//
// Signals:
//   start      master->slave  request a new adaptation
//   cnt_in     master->slave  per-road vehicle counts, road i at [i*CNT_W +: CNT_W]
//   tg_base    master->slave  per-road base green times, same packing
//   busy       slave->master  computation in progress
//   done       slave->master  one-cycle result-valid pulse
//   tg_out     slave->master  adapted green times
//   tot        slave->master  sum of snapshotted counts
//   avg        slave->master  floor(tot / NUM_ROADS)
//   state_dbg  slave->master  current FSM state encoding, for observation
interface green_time_adapter_if #(
    parameter int NUM_ROADS = 4,
    parameter int CNT_W     = 8,
    parameter int TG_W      = 8
);
    localparam int SW = CNT_W + $clog2(NUM_ROADS);

    logic                       start;
    logic [NUM_ROADS*CNT_W-1:0] cnt_in;
    logic [NUM_ROADS*TG_W-1:0]  tg_base;
    logic                       busy;
    logic                       done;
    logic [NUM_ROADS*TG_W-1:0]  tg_out;
    logic [SW-1:0]              tot;
    logic [CNT_W-1:0]           avg;
    logic [2:0]                 state_dbg;

    modport master (
        output start, cnt_in, tg_base,
        input  busy, done, tg_out, tot, avg, state_dbg
    );

    modport slave (
        input  start, cnt_in, tg_base,
        output busy, done, tg_out, tot, avg, state_dbg
    );
endinterface

// File: rtl/green_time_adapter.sv
// Green-time adaptation engine for an N-approach junction controller.
//
// On an accepted start, the engine snapshots the counts and the base times.
// It then takes one cycle per road to sum the counts, and one cycle to form
// the floored average. Next it takes one cycle per road to compute
// clamp(base + ((cnt - avg) >>> GAIN_SHIFT)) into a shadow register. Finally
// it publishes all results together with a done pulse.
// The latency from the accepting edge to done is 2*NUM_ROADS+2 cycles.
//
// Optional feature macro: ADAPT_SMOOTH_EN. When it is defined, the published
// green time is the floored mean of the previous output and the new clamped
// value.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high. It aborts any computation and loads
//          tg_out from tg_base.
//   bus    green_time_adapter_if.slave (start/cnt_in/tg_base in; busy/done/
//          tg_out/tot/avg/state_dbg out)
module green_time_adapter #(
    parameter int NUM_ROADS  = 4,
    parameter int CNT_W      = 8,
    parameter int TG_W       = 8,
    parameter int GAIN_SHIFT = 0,
    parameter int TG_MIN     = 5,
    parameter int TG_MAX     = 60
) (
    input  logic                  clk,
    input  logic                  reset,
    green_time_adapter_if.slave   bus
);
    localparam int LG = $clog2(NUM_ROADS);
    localparam int SW = CNT_W + LG;
    // Wide enough that base + delta can never wrap, whatever the widths.
    localparam int RW = ((TG_W > CNT_W) ? TG_W : CNT_W) + 2;
    localparam logic signed [RW-1:0] MIN_S = RW'(TG_MIN);
    localparam logic signed [RW-1:0] MAX_S = RW'(TG_MAX);
    localparam logic [LG-1:0] LAST = LG'(NUM_ROADS - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SUM  = 3'd1,
        AVG  = 3'd2,
        ADJ  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t            state;
    logic [LG-1:0]     idx;
    logic [SW-1:0]     acc;
    logic [CNT_W-1:0]  avg_r;
    logic [CNT_W-1:0]  cnt_snap [NUM_ROADS];
    logic [TG_W-1:0]   base_snap[NUM_ROADS];
    logic [TG_W-1:0]   shadow   [NUM_ROADS];
    logic [TG_W-1:0]   tg_r     [NUM_ROADS];
    logic              busy_r;
    logic              done_r;
    logic [SW-1:0]     tot_r;
    logic [CNT_W-1:0]  avg_o;

    // Adjustment for the road currently selected by idx.
    logic signed [CNT_W:0]  delta;
    logic signed [CNT_W:0]  d;
    logic signed [RW-1:0]   raw;
    logic [TG_W-1:0]        clamped;

    always_comb begin
        delta   = $signed({1'b0, cnt_snap[idx]}) - $signed({1'b0, avg_r});
        d       = delta >>> GAIN_SHIFT;
        raw     = $signed({{(RW-TG_W){1'b0}}, base_snap[idx]})
                + $signed({{(RW-CNT_W-1){d[CNT_W]}}, d});
        clamped = raw[TG_W-1:0];
        if (raw < MIN_S)
            clamped = TG_W'(TG_MIN);
        else if (raw > MAX_S)
            clamped = TG_W'(TG_MAX);
    end

    // Value published per road in DONE.
    logic [TG_W-1:0] publish[NUM_ROADS];
`ifdef ADAPT_SMOOTH_EN
    logic [TG_W:0] smooth_sum[NUM_ROADS];
    always_comb begin
        for (int i = 0; i < NUM_ROADS; i++) begin
            smooth_sum[i] = {1'b0, tg_r[i]} + {1'b0, shadow[i]};
            publish[i]    = smooth_sum[i][TG_W:1];
        end
    end
`else
    always_comb begin
        for (int i = 0; i < NUM_ROADS; i++)
            publish[i] = shadow[i];
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            idx    <= '0;
            acc    <= '0;
            avg_r  <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            tot_r  <= '0;
            avg_o  <= '0;
            for (int i = 0; i < NUM_ROADS; i++)
                tg_r[i] <= bus.tg_base[i*TG_W +: TG_W];
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    busy_r <= 1'b0;
                    if (bus.start) begin
                        for (int i = 0; i < NUM_ROADS; i++) begin
                            cnt_snap[i]  <= bus.cnt_in[i*CNT_W +: CNT_W];
                            base_snap[i] <= bus.tg_base[i*TG_W +: TG_W];
                        end
                        acc    <= '0;
                        idx    <= '0;
                        busy_r <= 1'b1;
                        state  <= SUM;
                    end
                end
                SUM: begin
                    acc <= acc + {{LG{1'b0}}, cnt_snap[idx]};
                    idx <= idx + 1'b1;
                    if (idx == LAST)
                        state <= AVG;
                end
                AVG: begin
                    avg_r <= CNT_W'(acc >> LG);
                    idx   <= '0;
                    state <= ADJ;
                end
                ADJ: begin
                    shadow[idx] <= clamped;
                    idx         <= idx + 1'b1;
                    if (idx == LAST)
                        state <= DONE;
                end
                DONE: begin
                    // busy stays high while done is visible; it drops in IDLE.
                    for (int i = 0; i < NUM_ROADS; i++)
                        tg_r[i] <= publish[i];
                    tot_r  <= acc;
                    avg_o  <= avg_r;
                    done_r <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_ROADS; i++)
            bus.tg_out[i*TG_W +: TG_W] = tg_r[i];
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.tot       = tot_r;
    assign bus.avg       = avg_o;
    assign bus.state_dbg = state;
endmodule

// File: tb/tb_green_time_adapter.sv
// Directed bench for green_time_adapter. It uses two instances that share the
// same stimulus: dut0 with GAIN_SHIFT=0 and dut1 with GAIN_SHIFT=1.
module tb_green_time_adapter;
    localparam int N  = 4;
    localparam int CW = 8;
    localparam int TW = 8;

    // clock / reset
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic          start;
    logic [31:0]   cnt_in;
    logic [31:0]   tg_base;

    green_time_adapter_if #(.NUM_ROADS(N), .CNT_W(CW), .TG_W(TW)) b0 ();
    green_time_adapter_if #(.NUM_ROADS(N), .CNT_W(CW), .TG_W(TW)) b1 ();

    assign b0.start = start;  assign b0.cnt_in = cnt_in;  assign b0.tg_base = tg_base;
    assign b1.start = start;  assign b1.cnt_in = cnt_in;  assign b1.tg_base = tg_base;

    green_time_adapter #(.NUM_ROADS(N), .CNT_W(CW), .TG_W(TW), .GAIN_SHIFT(0),
                         .TG_MIN(5), .TG_MAX(60))
        dut0 (.clk(clk), .reset(reset), .bus(b0.slave));
    green_time_adapter #(.NUM_ROADS(N), .CNT_W(CW), .TG_W(TW), .GAIN_SHIFT(1),
                         .TG_MIN(5), .TG_MAX(60))
        dut1 (.clk(clk), .reset(reset), .bus(b1.slave));

    int total = 0;
    int bad   = 0;

    function automatic logic [31:0] pk(input int a, input int b, input int c, input int d);
        logic [7:0] ra, rb, rc, rd;
        ra = a[7:0]; rb = b[7:0]; rc = c[7:0]; rd = d[7:0];
        return {rd, rc, rb, ra};
    endfunction

    // Expected published value given the previous output and the clamped result.
    function automatic logic [31:0] pub(input logic [31:0] prev, input logic [31:0] cl);
        logic [31:0] r;
        r = cl;
`ifdef ADAPT_SMOOTH_EN
        for (int i = 0; i < 4; i++)
            r[i*8 +: 8] = 8'((9'(prev[i*8 +: 8]) + 9'(cl[i*8 +: 8])) >> 1);
`else
        r = cl | (prev & 32'h0);
`endif
        return r;
    endfunction

    // scoreboard check
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Waits for done on dut0; lat = edges after the start edge, -1 on timeout.
    task automatic wait_done(input int max, output int lat);
        lat = -1;
        for (int k = 1; k <= max; k++) begin
            tick();
            if (b0.done === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    int          lat;
    int          ndone;
    logic [31:0] base30;

    initial begin
        reset   = 1'b0;
        start   = 1'b0;
        base30  = pk(30, 30, 30, 30);
        cnt_in  = pk(10, 20, 30, 40);
        tg_base = base30;

        // ---- reset state
        do_reset();
        chk("rst_busy", {31'd0, b0.busy}, 32'd0);
        chk("rst_done", {31'd0, b0.done}, 32'd0);
        chk("rst_tot",  {22'd0, b0.tot},  32'd0);
        chk("rst_avg",  {24'd0, b0.avg},  32'd0);
        chk("rst_tg",   b0.tg_out,        base30);
        chk("rst_state", {29'd0, b0.state_dbg}, 32'd0);

        // ---- scenario 1 (dut0) and 3 (dut1)
        pulse_start();
        chk("s1_busy", {31'd0, b0.busy}, 32'd1);
        wait_done(30, lat);
        chk("s1_lat",   lat, 32'd10);
        chk("s1_busy_done", {31'd0, b0.busy}, 32'd1);
        chk("s1_tot",   {22'd0, b0.tot}, 32'd100);
        chk("s1_avg",   {24'd0, b0.avg}, 32'd25);
        chk("s1_tg",    b0.tg_out, pub(base30, pk(15, 25, 35, 45)));
        chk("s3_done",  {31'd0, b1.done}, 32'd1);
        chk("s3_tot",   {22'd0, b1.tot}, 32'd100);
        chk("s3_tg",    b1.tg_out, pub(base30, pk(22, 27, 32, 37)));
        tick();
        chk("s1_pulse", {31'd0, b0.done}, 32'd0);
        chk("s1_idle_busy", {31'd0, b0.busy}, 32'd0);
        chk("s1_idle_state", {29'd0, b0.state_dbg}, 32'd0);

        // ---- scenario 2: clamps, inputs changed after snapshot
        cnt_in = pk(0, 0, 0, 200);
        do_reset();
        pulse_start();
        cnt_in  = pk(99, 7, 250, 1);
        tg_base = pk(1, 2, 3, 4);
        wait_done(30, lat);
        chk("s2_lat", lat, 32'd10);
        chk("s2_tot", {22'd0, b0.tot}, 32'd200);
        chk("s2_avg", {24'd0, b0.avg}, 32'd50);
        chk("s2_tg",  b0.tg_out, pub(base30, pk(5, 5, 5, 60)));
        chk("s2_tg_g1", b1.tg_out, pub(base30, pk(5, 5, 5, 60)));

        // ---- all counts zero: tg_out = clamp(base)
        cnt_in  = pk(0, 0, 0, 0);
        tg_base = pk(3, 30, 70, 40);
        do_reset();
        pulse_start();
        wait_done(30, lat);
        chk("z_tot", {22'd0, b0.tot}, 32'd0);
        chk("z_avg", {24'd0, b0.avg}, 32'd0);
        chk("z_tg",  b0.tg_out, pub(pk(3, 30, 70, 40), pk(5, 30, 60, 40)));

        // ---- scenario 4: re-pulsed start ignored, back-to-back accepted
        cnt_in  = pk(10, 20, 30, 40);
        tg_base = base30;
        do_reset();
        start = 1'b1;
        tick();                       // edge 0
        ndone = 0;
        for (int e = 1; e <= 10; e++) begin
            start = (e == 3 || e == 9);
            tick();
            start = 1'b0;
            if (e < 10 && b0.done === 1'b1) ndone++;
        end
        chk("s4_early_done", ndone, 32'd0);
        chk("s4_done10", {31'd0, b0.done}, 32'd1);
        chk("s4_tg", b0.tg_out, pub(base30, pk(15, 25, 35, 45)));
        start = 1'b1;
        tick();                       // edge 11
        start = 1'b0;
        chk("s4_busy11", {31'd0, b0.busy}, 32'd1);
        ndone = 0;
        for (int e = 12; e <= 20; e++) begin
            tick();
            if (b0.done === 1'b1) ndone++;
        end
        chk("s4_mid_done", ndone, 32'd0);
        tick();                       // edge 21
        chk("s4_done21", {31'd0, b0.done}, 32'd1);

        // ---- scenario 5: reset mid-computation aborts
        tg_base = pk(11, 12, 13, 14);
        do_reset();
        pulse_start();                // edge 0
        for (int e = 1; e <= 5; e++) tick();
        reset = 1'b1;
        tick();                       // edge 6
        reset = 1'b0;
        chk("s5_busy", {31'd0, b0.busy}, 32'd0);
        chk("s5_done", {31'd0, b0.done}, 32'd0);
        chk("s5_tot",  {22'd0, b0.tot},  32'd0);
        chk("s5_avg",  {24'd0, b0.avg},  32'd0);
        chk("s5_tg",   b0.tg_out, pk(11, 12, 13, 14));
        ndone = 0;
        for (int e = 0; e < 15; e++) begin
            tick();
            if (b0.done === 1'b1) ndone++;
        end
        chk("s5_no_done", ndone, 32'd0);

        // ---- reset and start together: reset wins
        reset = 1'b1;
        start = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        chk("rs_state", {29'd0, b0.state_dbg}, 32'd0);
        tick();
        chk("rs_busy", {31'd0, b0.busy}, 32'd0);

        // final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
